wb_target_bridge: RTL and testbench
===================================

Name: wb_target_bridge

Overview:
Parametrised Wishbone-classic slave front-end for the user project area. It sits between the management SoC Wishbone port and N_TGT internal register targets. It decodes the target window, runs a request/ack handshake to the selected target, bounds each access with a timeout, and reports errors. It replaces single-target direct wiring, so additional targets can be added without changing the wrapper.

Parameters:
N_TGT, 4, number of targets (1..16); IDX_W = max(1, clog2(N_TGT)) is derived.
DATA_W, 32, data width; SEL_W = DATA_W/8 is derived.
WIN_BITS, 12, per-target window size, in log2 bytes.
BASE_ADDR, 32'h3000_0000, bridge base; only bits [31:WIN_BITS+IDX_W] are compared.
TIMEOUT, 255, cycles to wait for tgt_ack before an error response (1..65535).
ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-high
wbs_adr  in  32  byte address
wbs_wdata  in  DATA_W  write data
wbs_sel  in  SEL_W  byte enables
wbs_cyc  in  1  bus cycle
wbs_stb  in  1  strobe
wbs_we  in  1  write enable
wbs_ack  out  1  registered ack, one-cycle pulse
wbs_rdata  out  DATA_W  read data, valid with wbs_ack
tgt_req  out  N_TGT  one-hot request, held until ack, timeout or abort
tgt_we  out  1  write flag (shared by all targets)
tgt_addr  out  WIN_BITS  offset within window
tgt_wdata  out  DATA_W  write data
tgt_sel  out  SEL_W  byte enables
tgt_ack  in  N_TGT  per-target ack
tgt_rdata  in  N_TGT*DATA_W  packed per-target read data; target i occupies slice i
err_irq  out  1  sticky error flag
err_clr  in  1  clears err_irq

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; wbs_ack=0, wbs_rdata=0, tgt_req=0, tgt_we=0, tgt_addr=0, tgt_wdata=0, tgt_sel=0, err_irq=0, timeout counter=0.
- Decode: hit when wbs_adr[31:WIN_BITS+IDX_W]==BASE_ADDR[31:WIN_BITS+IDX_W] and idx=wbs_adr[WIN_BITS+IDX_W-1:WIN_BITS] < N_TGT.
- Target outputs: tgt_* address, data, sel and we are captured in the IDLE->REQ cycle and held stable through REQ.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On cyc&stb with a hit: latch the request and go to REQ.
  - On cyc&stb with a miss: go to RESP with wbs_rdata=ERR_DATA and set err_irq. Writes are dropped; no tgt_req is raised.
- REQ:
  - tgt_req[idx]=1 and the counter increments each cycle.
  - tgt_ack[idx]=1: capture slice idx of tgt_rdata (writes capture 0), drop tgt_req, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: drop tgt_req, set wbs_rdata=ERR_DATA, set err_irq, go to RESP.
  - tgt_ack arriving together with the timeout edge: the ack wins.
  - tgt_ack on any non-selected bit is ignored.
  - wbs_cyc low: abort. Drop tgt_req, go to IDLE, no wbs_ack.
- RESP: wbs_ack=1 for exactly one cycle, then IDLE. wbs_rdata holds its value until the next response.
- Latency: a target that acks in the same cycle tgt_req rises gives wbs_ack 2 cycles after stb is sampled. A decode miss gives wbs_ack 1 cycle after.
- The master deasserts stb after ack, so IDLE never re-triggers on the same access.
- err_irq: sticky. Cleared by err_clr. When a set and err_clr occur in the same cycle, the set wins.
- The counter is cleared on every entry to REQ.

Optional Feature:
WB_BRIDGE_STATS_EN.
- Defined: adds output err_cnt (16 bits), a saturating count of decode errors plus timeouts.
  - Holds at 16'hFFFF once reached.
  - Cleared by err_clr.
  - A set and err_clr in the same cycle yields 1.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package wb_bridge_pkg holds the FSM state enum (IDLE/REQ/RESP), the ERR_DATA default and the clog2 helper for IDX_W.
- One sub-module, wb_addr_decode: purely combinational, computing hit and idx from wbs_adr.
- The FSM, timeout counter and error logic stay in wb_target_bridge.

Test Plan:
All scenarios use N_TGT=4, WIN_BITS=12, BASE_ADDR=0x3000_0000, TIMEOUT=8.
- Read 0x3000_2010, tgt2 acks 1 cycle after req with rdata 0x1234_5678 -> tgt_req=4'b0100, tgt_addr=0x010, wbs_rdata=0x1234_5678 with a one-cycle wbs_ack, err_irq=0.
- Write 0x3000_0004, data 0xA5A5_A5A5, sel 4'b0011, tgt0 acks immediately -> tgt_we=1, tgt_wdata=0xA5A5_A5A5, tgt_sel=4'b0011, wbs_ack 2 cycles after stb.
- Read 0x4000_0000 (base miss) -> no tgt_req; wbs_ack next cycle with 0xDEAD_BEEF; err_irq=1.
- Read 0x3000_1000, tgt1 never acks -> tgt_req[1] high 8 cycles then low; wbs_ack with 0xDEAD_BEEF; err_irq=1.
- Pulse err_clr while a timeout sets err_irq in the same cycle -> err_irq stays 1; a later lone err_clr -> 0.
- Drop wbs_cyc mid-REQ, then assert wb_rst during a second REQ -> tgt_req low next cycle with no wbs_ack; on reset all outputs 0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone target bridge: FSM state encoding,
// default error read data and the target-index width helper.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } bridge_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Index field is at least one bit wide, even for a single target.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational target-window decoder: compares the bridge base bits and
// extracts the target index from the upper part of the byte address.
module wb_addr_decode
  import wb_bridge_pkg::*;
#(
  parameter int unsigned  N_TGT     = 4,
  parameter int unsigned  WIN_BITS  = 12,
  parameter logic [31:0]  BASE_ADDR = 32'h3000_0000,
  localparam int unsigned IDX_W     = idx_width(N_TGT),
  localparam int unsigned TOP_LSB   = WIN_BITS + IDX_W
) (
  input  logic [31-WIN_BITS:0] adr_i,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic base_match;
  logic idx_ok;

  assign idx_o      = adr_i[IDX_W-1:0];
  assign base_match = (adr_i[31-WIN_BITS:IDX_W] == BASE_ADDR[31:TOP_LSB]);

  // When N_TGT fills the index field every index is valid.
  if (N_TGT == (32'd1 << IDX_W)) begin : g_full
    assign idx_ok = 1'b1;
  end else begin : g_part
    assign idx_ok = (32'(idx_o) < N_TGT);
  end

  assign hit_o = base_match & idx_ok;

endmodule

// File: rtl/wb_target_bridge.sv
// Wishbone-classic slave front-end fanning out to N_TGT register targets with
// timeout and sticky error reporting. Define WB_BRIDGE_STATS_EN to add err_cnt.
module wb_target_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned       N_TGT     = 4,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       WIN_BITS  = 12,
  parameter logic [31:0]       BASE_ADDR = 32'h3000_0000,
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(ERR_DATA_DEFAULT),
  localparam int unsigned      IDX_W     = idx_width(N_TGT),
  localparam int unsigned      SEL_W     = DATA_W / 8
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [31:0]             wbs_adr,
  input  logic [DATA_W-1:0]       wbs_wdata,
  input  logic [SEL_W-1:0]        wbs_sel,
  input  logic                    wbs_cyc,
  input  logic                    wbs_stb,
  input  logic                    wbs_we,
  output logic                    wbs_ack,
  output logic [DATA_W-1:0]       wbs_rdata,
  output logic [N_TGT-1:0]        tgt_req,
  output logic                    tgt_we,
  output logic [WIN_BITS-1:0]     tgt_addr,
  output logic [DATA_W-1:0]       tgt_wdata,
  output logic [SEL_W-1:0]        tgt_sel,
  input  logic [N_TGT-1:0]        tgt_ack,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  output logic                    err_irq,
  input  logic                    err_clr
`ifdef WB_BRIDGE_STATS_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  bridge_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  wbs_ack_q, wbs_ack_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [N_TGT-1:0]      tgt_req_q, tgt_req_d;
  logic                  tgt_we_q, tgt_we_d;
  logic [WIN_BITS-1:0]   tgt_addr_q, tgt_addr_d;
  logic [DATA_W-1:0]     tgt_wdata_q, tgt_wdata_d;
  logic [SEL_W-1:0]      tgt_sel_q, tgt_sel_d;
  logic                  err_irq_q, err_irq_d;
  logic                  err_set;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  sel_ack;
  logic [DATA_W-1:0]     sel_rdata;

  wb_addr_decode #(
    .N_TGT     (N_TGT),
    .WIN_BITS  (WIN_BITS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .adr_i (wbs_adr[31:WIN_BITS]),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  assign sel_ack   = tgt_ack[idx_q];
  assign sel_rdata = tgt_rdata[32'(idx_q) * DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wbs_ack_d   = 1'b0;
    rdata_d     = rdata_q;
    tgt_req_d   = tgt_req_q;
    tgt_we_d    = tgt_we_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    tgt_sel_d   = tgt_sel_q;
    err_set     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wbs_cyc && wbs_stb) begin
          if (dec_hit) begin
            state_d     = StReq;
            idx_d       = dec_idx;
            cnt_d       = '0;
            tgt_req_d   = N_TGT'(1) << dec_idx;
            tgt_we_d    = wbs_we;
            tgt_addr_d  = wbs_adr[WIN_BITS-1:0];
            tgt_wdata_d = wbs_wdata;
            tgt_sel_d   = wbs_sel;
          end else begin
            // Decode miss: nothing reaches a target, answer with error data.
            state_d   = StResp;
            wbs_ack_d = 1'b1;
            rdata_d   = ERR_DATA;
            err_set   = 1'b1;
          end
        end
      end
      StReq: begin
        if (!wbs_cyc) begin
          state_d   = StIdle;
          tgt_req_d = '0;
        end else if (sel_ack) begin
          // Ack takes priority over a coincident timeout.
          state_d   = StResp;
          tgt_req_d = '0;
          wbs_ack_d = 1'b1;
          rdata_d   = tgt_we_q ? '0 : sel_rdata;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d   = StResp;
          tgt_req_d = '0;
          wbs_ack_d = 1'b1;
          rdata_d   = ERR_DATA;
          err_set   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    err_irq_d = err_set | (err_irq_q & ~err_clr);
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      wbs_ack_q   <= 1'b0;
      rdata_q     <= '0;
      tgt_req_q   <= '0;
      tgt_we_q    <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      tgt_sel_q   <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wbs_ack_q   <= wbs_ack_d;
      rdata_q     <= rdata_d;
      tgt_req_q   <= tgt_req_d;
      tgt_we_q    <= tgt_we_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      tgt_sel_q   <= tgt_sel_d;
      err_irq_q   <= err_irq_d;
    end
  end

`ifdef WB_BRIDGE_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_set) begin
      if (err_clr) begin
        err_cnt_d = 16'd1;
      end else if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign wbs_ack   = wbs_ack_q;
  assign wbs_rdata = rdata_q;
  assign tgt_req   = tgt_req_q;
  assign tgt_we    = tgt_we_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_wdata = tgt_wdata_q;
  assign tgt_sel   = tgt_sel_q;
  assign err_irq   = err_irq_q;

endmodule

// File: tb/tb_wb_target_bridge.sv
// Randomized self-checking bench for wb_target_bridge (4 targets, timeout 8),
// using a transaction-level model of latency, returned data and error state.
module tb_wb_target_bridge;

  localparam int unsigned NTgt    = 4;
  localparam int unsigned Tmo     = 8;
  localparam logic [31:0] Base    = 32'h3000_0000;
  localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [31:0]   wbs_adr;
  logic [31:0]   wbs_wdata;
  logic [3:0]    wbs_sel;
  logic          wbs_cyc;
  logic          wbs_stb;
  logic          wbs_we;
  logic          wbs_ack;
  logic [31:0]   wbs_rdata;
  logic [3:0]    tgt_req;
  logic          tgt_we;
  logic [11:0]   tgt_addr;
  logic [31:0]   tgt_wdata;
  logic [3:0]    tgt_sel;
  logic [3:0]    tgt_ack;
  logic [127:0]  tgt_rdata;
  logic          err_irq;
  logic          err_clr;
`ifdef WB_BRIDGE_STATS_EN
  logic [15:0]   err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference error state.
  bit exp_err  = 1'b0;
  int exp_ecnt = 0;

  wb_target_bridge #(
    .N_TGT     (NTgt),
    .DATA_W    (32),
    .WIN_BITS  (12),
    .BASE_ADDR (Base),
    .TIMEOUT   (Tmo),
    .ERR_DATA  (ErrWord)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wbs_adr   (wbs_adr),
    .wbs_wdata (wbs_wdata),
    .wbs_sel   (wbs_sel),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_we    (wbs_we),
    .wbs_ack   (wbs_ack),
    .wbs_rdata (wbs_rdata),
    .tgt_req   (tgt_req),
    .tgt_we    (tgt_we),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_sel   (tgt_sel),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata),
    .err_irq   (err_irq),
    .err_clr   (err_clr)
`ifdef WB_BRIDGE_STATS_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_err_state(input string tag);
    check_eq({tag, "_err_irq"}, 32'(err_irq), 32'(exp_err));
`ifdef WB_BRIDGE_STATS_EN
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), exp_ecnt);
`endif
  endtask

  task automatic model_error(input bit clr_same);
    exp_err = 1'b1;
    if (clr_same) exp_ecnt = 1;
    else if (exp_ecnt < 65535) exp_ecnt = exp_ecnt + 1;
  endtask

  task automatic lone_clear();
    err_clr = 1'b1;
    @(posedge wb_clk); #1;
    err_clr  = 1'b0;
    exp_err  = 1'b0;
    exp_ecnt = 0;
    check_err_state("lone_clr");
  endtask

  // One full access; d is the number of REQ cycles before the target acks.
  task automatic run_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                         input logic [3:0] sel, input int d, input logic [127:0] rbus,
                         input bit clr_on_timeout);
    bit          hit;
    int          idx;
    logic [3:0]  onehot;
    bit          tmo;
    int          exp_reqc;
    logic [31:0] exp_data;
    int          n;
    int          reqc;
    bit          done;
    logic [3:0]  noise;

    hit      = (addr >> 14) == (Base >> 14);
    idx      = int'(addr[13:12]);
    onehot   = 4'b0001 << idx;
    tmo      = hit && (d >= Tmo);
    exp_reqc = !hit ? 0 : (tmo ? Tmo : d + 1);
    if (!hit || tmo) exp_data = ErrWord;
    else if (we)     exp_data = 32'h0;
    else             exp_data = rbus[idx*32 +: 32];

    tgt_rdata = rbus;
    wbs_adr   = addr;
    wbs_we    = we;
    wbs_wdata = wdata;
    wbs_sel   = sel;
    wbs_cyc   = 1'b1;
    wbs_stb   = 1'b1;
    n = 0; reqc = 0; done = 1'b0;

    while (!done && n < 40) begin
      @(posedge wb_clk); #1;
      n++;
      err_clr = 1'b0;
      tgt_ack = 4'b0;
      noise   = 4'($urandom);
      if (wbs_ack) begin
        done = 1'b1;
      end else if (tgt_req != 4'b0) begin
        reqc++;
        if (reqc == 1) begin
          check_eq("tgt_req", 32'(tgt_req), 32'(onehot));
          check_eq("tgt_addr", 32'(tgt_addr), 32'(addr[11:0]));
          check_eq("tgt_we", 32'(tgt_we), 32'(we));
          check_eq("tgt_wdata", tgt_wdata, wdata);
          check_eq("tgt_sel", 32'(tgt_sel), 32'(sel));
        end
        tgt_ack = noise & ~onehot;
        if (reqc - 1 == d) tgt_ack = tgt_ack | onehot;
        if (clr_on_timeout && tmo && reqc == Tmo) err_clr = 1'b1;
      end
    end

    check_eq("ack_seen", 32'(done), 32'd1);
    check_eq("ack_latency", n, exp_reqc + 1);
    check_eq("req_cycles", reqc, exp_reqc);
    check_eq("rdata", wbs_rdata, exp_data);
    if (!hit || tmo) model_error(clr_on_timeout);
    check_err_state("txn");

    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    tgt_ack = 4'b0;
    err_clr = 1'b0;
    @(posedge wb_clk); #1;
    check_eq("ack_pulse", 32'(wbs_ack), 32'd0);
    check_eq("req_idle", 32'(tgt_req), 32'd0);
    check_eq("rdata_hold", wbs_rdata, exp_data);
  endtask

  task automatic run_abort(input logic [31:0] addr);
    int n;
    int reqc;
    wbs_adr = addr;
    wbs_we  = 1'b0;
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    tgt_ack = 4'b0;
    n = 0; reqc = 0;
    while (reqc < 2 && n < 10) begin
      @(posedge wb_clk); #1;
      n++;
      if (tgt_req != 4'b0) reqc++;
    end
    check_eq("abort_reached_req", reqc, 2);
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk); #1;
      check_eq("abort_req", 32'(tgt_req), 32'd0);
      check_eq("abort_ack", 32'(wbs_ack), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ack"}, 32'(wbs_ack), 32'd0);
    check_eq({tag, "_rdata"}, wbs_rdata, 32'd0);
    check_eq({tag, "_req"}, 32'(tgt_req), 32'd0);
    check_eq({tag, "_we"}, 32'(tgt_we), 32'd0);
    check_eq({tag, "_addr"}, 32'(tgt_addr), 32'd0);
    check_eq({tag, "_wdata"}, tgt_wdata, 32'd0);
    check_eq({tag, "_sel"}, 32'(tgt_sel), 32'd0);
    check_eq({tag, "_err_irq"}, 32'(err_irq), 32'd0);
  endtask

  task automatic run_reset_mid_req(input logic [31:0] addr);
    int n;
    wbs_adr   = addr;
    wbs_we    = 1'b1;
    wbs_wdata = 32'hCAFE_F00D;
    wbs_sel   = 4'hF;
    wbs_cyc   = 1'b1;
    wbs_stb   = 1'b1;
    tgt_ack   = 4'b0;
    n = 0;
    while (tgt_req == 4'b0 && n < 10) begin
      @(posedge wb_clk); #1;
      n++;
    end
    check_eq("rst_reached_req", 32'(tgt_req != 4'b0), 32'd1);
    #2;
    wb_rst = 1'b1;
    #1;
    exp_err  = 1'b0;
    exp_ecnt = 0;
    check_all_zero("rst_async");
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    check_eq("rst_idle_ack", 32'(wbs_ack), 32'd0);
    check_eq("rst_idle_req", 32'(tgt_req), 32'd0);
  endtask

  initial begin
    logic [127:0] rb;
    wb_rst    = 1'b1;
    wbs_adr   = '0;
    wbs_wdata = '0;
    wbs_sel   = '0;
    wbs_cyc   = 1'b0;
    wbs_stb   = 1'b0;
    wbs_we    = 1'b0;
    tgt_ack   = '0;
    tgt_rdata = '0;
    err_clr   = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;

    // Directed accesses.
    rb = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
    run_txn(32'h3000_2010, 1'b0, 32'h0, 4'hF, 1, rb, 1'b0);
    run_txn(32'h3000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 0, rb, 1'b0);
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, rb, 1'b0);
    run_txn(32'h3000_1000, 1'b0, 32'h0, 4'hF, 100, rb, 1'b0);
    lone_clear();
    // Coincident timeout set and clear: set wins.
    run_txn(32'h3000_3000, 1'b0, 32'h0, 4'hF, 100, rb, 1'b1);
    lone_clear();
    // Ack exactly on the timeout edge wins.
    run_txn(32'h3000_3ffc, 1'b0, 32'h0, 4'hF, Tmo - 1, {$urandom, $urandom, $urandom, $urandom},
            1'b0);
    run_abort(32'h3000_1008);
    run_txn(32'h4000_1000, 1'b0, 32'h0, 4'hF, 0, rb, 1'b0);
    run_reset_mid_req(32'h3000_2000);

    // Randomized accesses.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = {Base[31:14], a[13:0]};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 10), rb,
              ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 5) == 0) lone_clear();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
